comp_serial: RTL

//  Multi-cycle, digit-serial magnitude/equality comparator with selectable

---
 rtl/comp_serial.sv | 125 ++++++++++++
 1 files changed

// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - digit-serial magnitude/equality comparator, CHUNK bits per clock, LSB first
module comp_serial #(
    parameter int N     = 8,
    parameter int M     = N,
    parameter int CHUNK = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         sgn,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    output logic         busy,
    output logic         valid,
    output logic         o
);
    localparam int K  = (N + CHUNK - 1) / CHUNK;
    localparam int W  = K * CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_r, bb_r, a_nx, bb_nx;
    logic [2:0]     op_r, op_nx;
    logic           c_r, c_nx, e_r, e_nx;
    logic [IW-1:0]  idx, idx_nx;
    logic           valid_nx, o_nx;
    logic [N-1:0]   a_b, bb_b;
    logic [CHUNK-1:0] ca, cb;
    logic           cy, c_chunk, e_chunk;

    // Extend b to N bits, then flip the MSBs so a signed compare becomes unsigned.
    always_comb begin
        a_b  = a;
        bb_b = N'(b);
        for (int i = M; i < N; i++) begin
            bb_b[i] = sgn & b[M-1];
        end
        a_b[N-1]  = a[N-1] ^ sgn;
        bb_b[N-1] = bb_b[N-1] ^ sgn;
    end

    // Bits beyond N are zero in both operands, so padding passes carry and e through.
    always_comb begin
        ca = a_r[idx*CHUNK +: CHUNK];
        cb = bb_r[idx*CHUNK +: CHUNK];
        cy = c_r;
        for (int j = 0; j < CHUNK; j++) begin
            cy = (ca[j] & ~cb[j]) | (ca[j] & cy) | (~cb[j] & cy);
        end
        c_chunk = cy;
        e_chunk = e_r & (ca == cb);
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_r;
        bb_nx    = bb_r;
        op_nx    = op_r;
        c_nx     = c_r;
        e_nx     = e_r;
        idx_nx   = idx;
        valid_nx = 1'b0;
        o_nx     = o;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    a_nx     = W'(a_b);
                    bb_nx    = W'(bb_b);
                    op_nx    = op;
                    c_nx     = (op == 3'd0) || (op == 3'd3);
                    e_nx     = 1'b1;
                    idx_nx   = '0;
                end
            end
            RUN: begin
                c_nx   = c_chunk;
                e_nx   = e_chunk;
                idx_nx = idx + 1'b1;
                if (idx == IW'(K - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    valid_nx = 1'b1;
                    case (op_r)
                        3'd0, 3'd1: o_nx = c_chunk;
                        3'd2, 3'd3: o_nx = ~c_chunk;
                        3'd4:       o_nx = e_chunk;
                        3'd5:       o_nx = ~e_chunk;
                        default:    o_nx = 1'b0;
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            bb_r  <= '0;
            op_r  <= '0;
            c_r   <= 1'b0;
            e_r   <= 1'b0;
            idx   <= '0;
            valid <= 1'b0;
            o     <= 1'b0;
        end else begin
            state <= state_nx;
            a_r   <= a_nx;
            bb_r  <= bb_nx;
            op_r  <= op_nx;
            c_r   <= c_nx;
            e_r   <= e_nx;
            idx   <= idx_nx;
            valid <= valid_nx;
            o     <= o_nx;
        end
    end

    assign busy = (state == RUN);
endmodule
